// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: a round-robin arbiter that shares one FIFO write port
// among N producers. Each grant lasts for at most MAX_BURST accepted words.
// The grant ends early if the granted producer drops its request, and it
// stalls without counting while the FIFO reports full. Consecutive grants are
// always separated by one IDLE cycle.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] din_bus,
  input  logic            fifo_full,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    gnt,
  output logic            fifo_write,
  output logic [DW-1:0]   fifo_din,
  output logic            busy
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(MAX_BURST) + 1;

  localparam logic [CW-1:0]  LAST_CNT    = CW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] LAST_ID_RST = IDW'(N - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t         state;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] last_id;
  logic [CW-1:0]  burst_cnt;

  logic           pick_valid;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] cand;
  logic           cur_req;
  logic           accept;
  logic           end_burst;

  // Round-robin search: the first requester at or after last_id+1, wrapping modulo N.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves
    // a value held over from an earlier evaluation. Without the defaults,
    // synthesis would infer a latch.
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDW'((int'(last_id) + i) % N);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Write-side datapath: derived from the registered grant and the live inputs.
  always_comb begin
    cur_req    = req[cur_id];
    accept     = (state == S_GRANT) && cur_req && !fifo_full;
    end_burst  = (state == S_GRANT) && (!cur_req || (accept && (burst_cnt == LAST_CNT)));
    fifo_write = accept;
    ack        = accept ? (N'(1) << cur_id) : '0;
    fifo_din   = (state == S_GRANT) ? din_bus[int'(cur_id)*DW +: DW] : '0;
  end

  // Arbitration FSM, with the registered grant, busy flag and burst counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      cur_id    <= '0;
      last_id   <= LAST_ID_RST;
      burst_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments. All of them then
      // update together at the edge, and the order of the statements does not
      // change the result.
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state     <= S_GRANT;
            gnt       <= N'(1) << pick_id;
            cur_id    <= pick_id;
            burst_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        S_GRANT: begin
          if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (end_burst) begin
            state   <= S_IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            last_id <= cur_id;
          end
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: a table of per-cycle vectors {req, fifo_full,
// expected gnt, expected ack} that exercises bursts, round-robin order,
// full stalls, an early drop and a priority wrap. A scoreboard queue holds the
// expected FIFO words, and a hand-written sequence covers reset mid-burst.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N*DW-1:0] din_bus;
  logic            fifo_full;
  logic [N-1:0]    ack;
  logic [N-1:0]    gnt;
  logic            fifo_write;
  logic [DW-1:0]   fifo_din;
  logic            busy;

  fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .din_bus    (din_bus),
    .fifo_full  (fifo_full),
    .ack        (ack),
    .gnt        (gnt),
    .fifo_write (fifo_write),
    .fifo_din   (fifo_din),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic         full;
    logic [N-1:0] gnt;
    logic [N-1:0] ack;
  } vec_t;

  vec_t           vecs[$];
  logic [DW-1:0]  sb_q[$];
  int             prod_idx[N];
  int             total_cnt;
  int             pass_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] word_of(input int k);
    return 8'hA0 + 8'(k * 16) + 8'(prod_idx[k]);
  endfunction

  task automatic drive_din();
    for (int k = 0; k < N; k++) din_bus[k*DW +: DW] = word_of(k);
  endtask

  function automatic void add(input int n, input logic [N-1:0] r, input logic f,
                              input logic [N-1:0] g, input logic [N-1:0] a);
    vec_t v;
    v.req = r; v.full = f; v.gnt = g; v.ack = a;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  // Apply one vector for a whole cycle, check at the falling edge, then advance.
  task automatic apply(input int idx, input vec_t v);
    logic [DW-1:0] exp_word;
    req       = v.req;
    fifo_full = v.full;
    drive_din();
    @(negedge clk);
    check($sformatf("v%0d_gnt", idx), 32'(gnt), 32'(v.gnt));
    check($sformatf("v%0d_ack", idx), 32'(ack), 32'(v.ack));
    check($sformatf("v%0d_write", idx), 32'(fifo_write), 32'(|v.ack));
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'(|v.gnt));
    for (int k = 0; k < N; k++) begin
      if (v.ack[k]) begin
        sb_q.push_back(word_of(k));
        prod_idx[k]++;
      end
    end
    if (fifo_write) begin
      if (sb_q.size() == 0) begin
        check($sformatf("v%0d_sb_underflow", idx), 32'(fifo_write), 32'd0);
      end else begin
        exp_word = sb_q.pop_front();
        check($sformatf("v%0d_din", idx), 32'(fifo_din), 32'(exp_word));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    for (int k = 0; k < N; k++) prod_idx[k] = 0;

    // Single burst of A0..A5: four words, an IDLE bubble, a re-grant, two words, then a drop.
    add(1, 4'b0001, 1'b0, 4'b0000, 4'b0000);
    add(4, 4'b0001, 1'b0, 4'b0001, 4'b0001);
    add(1, 4'b0001, 1'b0, 4'b0000, 4'b0000);
    add(2, 4'b0001, 1'b0, 4'b0001, 4'b0001);
    add(1, 4'b0000, 1'b0, 4'b0001, 4'b0000);
    add(1, 4'b0000, 1'b0, 4'b0000, 4'b0000);
    // Round-robin with all four requesting, starting after last grant 0.
    add(1, 4'b1111, 1'b0, 4'b0000, 4'b0000);
    add(4, 4'b1111, 1'b0, 4'b0010, 4'b0010);
    add(1, 4'b1111, 1'b0, 4'b0000, 4'b0000);
    add(4, 4'b1111, 1'b0, 4'b0100, 4'b0100);
    add(1, 4'b1111, 1'b0, 4'b0000, 4'b0000);
    add(4, 4'b1111, 1'b0, 4'b1000, 4'b1000);
    add(1, 4'b1111, 1'b0, 4'b0000, 4'b0000);
    add(4, 4'b1111, 1'b0, 4'b0001, 4'b0001);
    // Full stall on requester 1: two writes, three stalled cycles, two writes.
    add(1, 4'b0010, 1'b0, 4'b0000, 4'b0000);
    add(2, 4'b0010, 1'b0, 4'b0010, 4'b0010);
    add(3, 4'b0010, 1'b1, 4'b0010, 4'b0000);
    add(2, 4'b0010, 1'b0, 4'b0010, 4'b0010);
    // Early drop by requester 2 while requester 3 waits.
    add(1, 4'b1100, 1'b0, 4'b0000, 4'b0000);
    add(2, 4'b1100, 1'b0, 4'b0100, 4'b0100);
    add(1, 4'b1000, 1'b0, 4'b0100, 4'b0000);
    add(1, 4'b1000, 1'b0, 4'b0000, 4'b0000);
    add(1, 4'b1000, 1'b0, 4'b1000, 4'b1000);
    add(1, 4'b0000, 1'b0, 4'b1000, 4'b0000);
    // Priority skip: last grant 3, only req[2] set, so the search wraps past 0 and 1.
    add(1, 4'b0100, 1'b0, 4'b0000, 4'b0000);
    add(1, 4'b0100, 1'b0, 4'b0100, 4'b0100);
    add(1, 4'b0000, 1'b0, 4'b0100, 4'b0000);
    add(2, 4'b0000, 1'b0, 4'b0000, 4'b0000);

    // Reset state, with requests present to show that ack stays low.
    rstn      = 1'b0;
    req       = 4'b1111;
    fifo_full = 1'b0;
    drive_din();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_write", 32'(fifo_write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_din", 32'(fifo_din), 32'd0);
    req = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    // Reset mid-burst: two writes from requester 0, then an asynchronous reset.
    req = 4'b0001;
    drive_din();
    @(posedge clk);
    #1;
    check("mid_gnt", 32'(gnt), 32'b0001);
    @(negedge clk);
    check("mid_w1", 32'(fifo_din), 32'(word_of(0)));
    prod_idx[0]++;
    @(posedge clk);
    #1;
    drive_din();
    @(negedge clk);
    check("mid_w2", 32'(fifo_din), 32'(word_of(0)));
    prod_idx[0]++;
    @(posedge clk);
    #1;
    drive_din();
    #2;
    rstn = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_ack", 32'(ack), 32'd0);
    check("arst_write", 32'(fifo_write), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_din", 32'(fifo_din), 32'd0);
    req = 4'b1111;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_gnt", 32'(gnt), 32'b0001);
    check("post_rst_busy", 32'(busy), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one 16-deep x 8-bit synchronous FIFO write port between N producers.
- Grants one producer at a time for a bounded burst, forwards that producer's data and write strobe to the FIFO, and respects FIFO full.
- Sits between producer blocks and the shared FIFO's write/din/full pins.

Parameters:
- N, 4, number of requesters (2..8)
- DW, 8, data width; must match FIFO din width
- MAX_BURST, 4, maximum accepted writes per grant (1..16)

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- req  input  N  per-requester write request; held high while data is valid
- din_bus  input  N*DW  requester data, requester k at bits [k*DW +: DW]
- fifo_full  input  1  FIFO full flag
- ack  output  N  one-hot; ack[k]=1 means requester k's word is written this cycle
- gnt  output  N  registered one-hot current grant; 0 when idle
- fifo_write  output  1  FIFO write strobe
- fifo_din  output  DW  FIFO write data
- busy  output  1  high while in GRANT state

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-low on rstn.
- Reset values:
  - state=IDLE, gnt=0, busy=0, burst_cnt=0.
  - last_id=N-1, so the first priority goes to requester 0.
  - ack=0, fifo_write=0, fifo_din=0.
- States:
  - IDLE:
    - if req!=0, select the first set req[k] searching from last_id+1 upward with modulo-N wrap.
    - Register gnt=one-hot(k), cur_id=k, burst_cnt=0, then go to GRANT.
    - If req==0, stay in IDLE.
  - GRANT:
    - accept = req[cur_id] && !fifo_full. All outputs below are combinational from registered state and inputs.
    - fifo_write=accept, ack[cur_id]=accept.
    - fifo_din = din_bus slice of cur_id while in GRANT, else 0.
    - On accept: burst_cnt+1. If burst_cnt==MAX_BURST-1, go to IDLE and set last_id=cur_id.
    - If req[cur_id]==0, go to IDLE with no write and set last_id=cur_id.
    - If fifo_full && req[cur_id], hold GRANT with no write and no count.
- Grant timing and fairness:
  - Grant latency is 1 cycle: req rises at edge t, gnt is asserted after edge t+1, first write occurs in cycle t+1 if not full.
  - One mandatory IDLE bubble cycle between consecutive grants, including a re-grant to the same requester.
  - A requester that reaches MAX_BURST gets lowest priority next round. If it is the only requester, it is re-granted after the bubble.
- Boundary conditions:
  - Requests from non-granted requesters are ignored until the next arbitration. Their ack stays 0 and producers must hold data.
  - Only one ack bit is ever high; ack is never high while fifo_full=1.
  - fifo_full toggling mid-burst stalls without losing or duplicating words. Burst length counts accepted words only.
  - A requester dropping req mid-burst ends the burst; it has no minimum length.
  - rstn asserted mid-burst forces all outputs to reset values immediately (asynchronously). Unaccepted data is the producer's responsibility.
- Arithmetic: burst_cnt is ceil(log2(MAX_BURST))+1 bits. cur_id/last_id is ceil(log2(N)) bits. Modulo-N wrap is explicit for N not a power of 2.

Test Plan:
- Single burst: req=0001 held, din0=A0..A5, fifo_full=0 -> writes A0-A3 on 4 consecutive cycles, 1 idle cycle with gnt=0, re-grant, then A4-A5 written.
- Round-robin: req=1111 held, continuous data -> grant order 0,1,2,3,0. Each gnt lasts 4 writes, with ack matching gnt on every write cycle.
- Full stall: grant 1 active, fifo_full=1 for 3 cycles after 2 writes -> fifo_write=0 and ack=0 during the stall, gnt held at 0010, then 2 more writes and release.
- Early drop: req[2] high for 2 cycles within its grant, req[3] also high -> 2 writes from requester 2, then IDLE, then grant 1000.
- Priority skip: last grant=3, req=0100 -> next grant=0100 (wrap past 0 and 1). req=0000 -> stays IDLE, busy=0.
- Reset mid-burst: rstn low after 2 writes -> gnt, ack and fifo_write go to 0 immediately. After release with req=1111, the first grant is requester 0.
